twiddle_sched_64p: RTL and testbench
====================================

# twiddle_sched_64p

Sequencer for the 64-point radix-2 DIF FFT butterfly datapath. Walks all 6 stages × 32 butterflies and, for each butterfly, emits the stage and butterfly index and the twiddle exponent. It also classifies the twiddle: trivial twiddles (W^0, W^16) are routed through the 32-bit bypass unit with the matching TYPESEL code. All other twiddles go to the complex multiplier with a ROM address. Outputs use a valid/ready handshake toward the butterfly issue stage.

## Interface
- STAGE_GAP, default 2: idle cycles inserted between stages for pipeline drain (0..15).
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  one-cycle pulse; begins a transform when idle.
- ABORT  in  1  synchronous cancel of a running transform.
- INV  in  1  inverse transform select (present only with TWSCHED_IFFT_EN).
- OUT_READY  in  1  downstream accepts current command.
- OUT_VALID  out  1  command fields valid.
- STAGE  out  3  stage index 0..5.
- BFLY  out  5  butterfly index 0..31.
- TW_ADDR  out  5  twiddle exponent k of W64^k.
- BYPASS  out  1  1 = trivial twiddle, use bypass unit.
- TYPESEL  out  3  bypass control: bit2 swap re/im, bit1 negate real, bit0 negate imag.
- LAST  out  1  final butterfly of final stage.
- BUSY  out  1  transform in progress.
- DONE  out  1  one-cycle completion pulse.

## Operation
- FSM states are IDLE, RUN, GAP and FIN.
- IDLE: on START go to RUN with STAGE=0, BFLY=0. START is ignored in any other state.
- RUN: OUT_VALID=1. Fields are held stable until OUT_VALID&&OUT_READY. Each handshake advances BFLY.
- After the handshake on BFLY=31:
  - If STAGE<5 and STAGE_GAP>0: go to GAP.
  - If STAGE<5 and STAGE_GAP=0: go directly to the next stage, BFLY=0.
  - If STAGE=5: go to FIN.
- GAP: OUT_VALID=0 for exactly STAGE_GAP cycles, then RUN with STAGE+1, BFLY=0.
- FIN: DONE=1 for one cycle, then IDLE.
- BUSY=1 in RUN, GAP and FIN.
- Twiddle exponent: k = (BFLY & ((32>>STAGE)−1)) << STAGE, 5-bit result. TW_ADDR=k.
- Classification:
  - k=0: BYPASS=1, TYPESEL=000 (pass).
  - k=16: BYPASS=1, TYPESEL=101 (×−j: re←im, im←−re).
  - Otherwise: BYPASS=0, TYPESEL=000.
- LAST = (STAGE==5 && BFLY==31 && OUT_VALID).
- ABORT in any non-IDLE state:
  - Next state is IDLE; OUT_VALID and BUSY drop the next cycle; no DONE.
  - ABORT has priority over a simultaneous handshake.
- START coincident with ABORT in IDLE: START wins.

## Timing
- All outputs are registered.
- Reset value of every output is 0; state IDLE, counters 0.
- START accepted at cycle t → OUT_VALID=1 at t+1 (stage 0, bfly 0).
- Throughput is one command per cycle when OUT_READY=1.
- OUT_READY=0 stalls with all fields frozen. OUT_VALID never deasserts without a handshake, except on ABORT.
- With OUT_READY=1: stage s occupies cycles t+1+s·(32+STAGE_GAP) … +31. DONE comes one cycle after the last handshake.
- Asserting RST_N low mid-transform clears all outputs immediately (asynchronous).

## Configuration
- TWSCHED_IFFT_EN defined:
  - Adds the INV port, sampled at START and held for the whole transform.
  - When INV=1, k=16 maps to TYPESEL=110 (×+j: re←−im, im←re).
  - TW_ADDR remains k; the conjugate is handled downstream.
- TWSCHED_IFFT_EN undefined: no INV port; forward transform only.

## Structure
- Shared package fft64_pkg holds:
  - FFT_N=64, FFT_STAGES=6, FFT_BFLY=32.
  - TYPESEL constants TS_PASS=3'b000, TS_MUL_NJ=3'b101, TS_MUL_PJ=3'b110.
  - FSM state encoding.
- One sub-module, twiddle_class: combinational mapping from (STAGE, BFLY, INV) to k, BYPASS and TYPESEL. The sequencer registers its outputs.

## Test plan
- Reset, then a START pulse with OUT_READY=1 and STAGE_GAP=2:
  - 192 handshakes occur; OUT_VALID is low for 2 cycles between stages.
  - Last handshake occurs 202 cycles after START, with LAST=1.
  - DONE=1 at +203.
- Field check:
  - stage0/bfly5 → TW_ADDR=5, BYPASS=0.
  - stage0/bfly16 → TW_ADDR=16, BYPASS=1, TYPESEL=101.
  - stage1/bfly24 → TW_ADDR=16, BYPASS=1.
  - All of stage 5 → TW_ADDR=0, BYPASS=1, TYPESEL=000.
- Random OUT_READY backpressure: fields are stable while OUT_VALID&&!OUT_READY; the sequence is identical to the unstalled run; no commands are lost or duplicated.
- ABORT in stage 3 at bfly 10:
  - Next cycle OUT_VALID=0, BUSY=0, no DONE.
  - A new START then restarts at stage 0/bfly 0.
- START while BUSY is ignored. RST_N pulsed low mid-stage → all outputs 0 asynchronously.
- With TWSCHED_IFFT_EN and INV=1: stage0/bfly16 → TYPESEL=110; k=0 entries stay 000.

Source files
------------

// File: rtl/fft64_pkg.sv
// fft64_pkg: shared FFT-64 constants, bypass TYPESEL codes and sequencer state encoding.
package fft64_pkg;
  localparam int FFT_N = 64;
  localparam int FFT_STAGES = 6;
  localparam int FFT_BFLY = 32;
  localparam logic [2:0] TS_PASS = 3'b000;
  localparam logic [2:0] TS_MUL_NJ = 3'b101;
  localparam logic [2:0] TS_MUL_PJ = 3'b110;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_GAP, ST_FIN} state_t;
endpackage

// File: rtl/twiddle_class.sv
// twiddle_class: maps (stage, bfly, inv) to twiddle exponent k and bypass/TYPESEL classification.
module twiddle_class
  import fft64_pkg::*;
(
  input  logic [2:0] stage,
  input  logic [4:0] bfly,
  input  logic       inv,
  output logic [4:0] k,
  output logic       bypass,
  output logic [2:0] typesel
);
  // Masking bfly to its low (5-stage) bits before the shift is implied by the 5-bit truncation.
  assign k = bfly << stage;
  assign bypass = k == 5'd0 || k == 5'd16;
  assign typesel = (k == 5'd16) ? (inv ? TS_MUL_PJ : TS_MUL_NJ) : TS_PASS;
endmodule

// File: rtl/twiddle_sched_64p.sv
// twiddle_sched_64p: 64-point radix-2 DIF butterfly/twiddle sequencer with valid/ready output.
// Optional TWSCHED_IFFT_EN adds the inv port (inverse transform, k=16 uses x(+j)).
module twiddle_sched_64p
  import fft64_pkg::*;
#(
  parameter int STAGE_GAP = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
`ifdef TWSCHED_IFFT_EN
  input  logic       inv,
`endif
  input  logic       out_ready,
  output logic       out_valid,
  output logic [2:0] stage,
  output logic [4:0] bfly,
  output logic [4:0] tw_addr,
  output logic       bypass,
  output logic [2:0] typesel,
  output logic       last,
  output logic       busy,
  output logic       done
);
  state_t state, nxt_state;
  logic [2:0] nxt_stage;
  logic [4:0] nxt_bfly, k;
  logic [3:0] gap_cnt, nxt_gap;
  logic inv_in, inv_q, nxt_inv, byp, run_n;
  logic [2:0] ts;
`ifdef TWSCHED_IFFT_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif
  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    nxt_bfly = bfly;
    nxt_gap = gap_cnt;
    nxt_inv = inv_q;
    case (state)
      ST_IDLE: if (start) begin
        nxt_state = ST_RUN;
        nxt_stage = 3'd0;
        nxt_bfly = 5'd0;
        nxt_inv = inv_in;
      end
      ST_RUN: if (abort) nxt_state = ST_IDLE;
      else if (out_ready) begin
        if (bfly != 5'd31) nxt_bfly = bfly + 5'd1;
        else if (stage == 3'(FFT_STAGES - 1)) nxt_state = ST_FIN;
        else if (STAGE_GAP == 0) begin
          nxt_stage = stage + 3'd1;
          nxt_bfly = 5'd0;
        end else begin
          nxt_state = ST_GAP;
          nxt_gap = 4'(STAGE_GAP - 1);
        end
      end
      ST_GAP: if (abort) nxt_state = ST_IDLE;
      else if (gap_cnt == 4'd0) begin
        nxt_state = ST_RUN;
        nxt_stage = stage + 3'd1;
        nxt_bfly = 5'd0;
      end else nxt_gap = gap_cnt - 4'd1;
      default: nxt_state = ST_IDLE;
    endcase
  end
  assign run_n = nxt_state == ST_RUN;
  // Classify the next command so the twiddle fields land registered alongside stage/bfly.
  twiddle_class u_class (
    .stage(nxt_stage),
    .bfly(nxt_bfly),
    .inv(nxt_inv),
    .k(k),
    .bypass(byp),
    .typesel(ts)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      stage <= '0;
      bfly <= '0;
      gap_cnt <= '0;
      inv_q <= 1'b0;
      out_valid <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      tw_addr <= '0;
      bypass <= 1'b0;
      typesel <= TS_PASS;
      last <= 1'b0;
    end else begin
      state <= nxt_state;
      stage <= nxt_stage;
      bfly <= nxt_bfly;
      gap_cnt <= nxt_gap;
      inv_q <= nxt_inv;
      out_valid <= run_n;
      busy <= nxt_state != ST_IDLE;
      done <= nxt_state == ST_FIN;
      tw_addr <= run_n ? k : 5'd0;
      bypass <= run_n && byp;
      typesel <= run_n ? ts : TS_PASS;
      last <= run_n && nxt_stage == 3'd5 && nxt_bfly == 5'd31;
    end
  end
endmodule

// File: tb/tb_twiddle_sched_64p.sv
// tb_twiddle_sched_64p: scoreboard bench for the 64-point twiddle sequencer (default forward build).
module tb_twiddle_sched_64p;
  localparam int GAP = 2;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, out_ready = 0;
  logic out_valid, bypass, last, busy, done;
  logic [2:0] stage, typesel;
  logic [4:0] bfly, tw_addr;
  logic [17:0] fld;
  assign fld = {stage, bfly, tw_addr, bypass, typesel, last};

  twiddle_sched_64p #(.STAGE_GAP(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out_ready(out_ready),
    .out_valid(out_valid), .stage(stage), .bfly(bfly), .tw_addr(tw_addr),
    .bypass(bypass), .typesel(typesel), .last(last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  logic [17:0] exp_f[192];
  logic [17:0] got_f[192];
  initial begin
    for (int s = 0; s < 6; s++)
      for (int b = 0; b < 32; b++) begin
        int kk;
        kk = ((b & ((32 >> s) - 1)) << s) % 32;
        exp_f[s*32+b] = {3'(s), 5'(b), 5'(kk), (kk == 0 || kk == 16),
                         (kk == 16) ? 3'b101 : 3'b000, (s == 5 && b == 31)};
      end
  end

  // Scoreboard: every accepted command must follow the stage-major, bfly-minor order.
  int idx = 0, rel = 0, gap_run = 0, last_rel = -1, done_rel = -1;
  bit held = 0;
  logic [17:0] held_f;
  always @(negedge clk) begin
    if (!rst_n) begin
      idx = 0;
      held = 0;
      gap_run = 0;
    end else begin
      rel++;
      if (held) chk("stall_hold", {13'd0, out_valid, fld}, {13'd0, 1'b1, held_f});
      held = 0;
      if (out_valid && !out_ready && !abort) begin
        held = 1;
        held_f = fld;
      end
      if (out_valid && out_ready && !abort) begin
        if (idx < 192) begin
          chk($sformatf("seq[%0d]", idx), {14'd0, fld}, {14'd0, exp_f[idx]});
          got_f[idx] = fld;
          if (idx == 191) last_rel = rel;
        end else chk("extra_cmd", idx, 191);
        idx++;
      end
      if (busy && !out_valid && !done) gap_run++;
      else begin
        if (out_valid && gap_run > 0) chk("gap_len", gap_run, GAP);
        gap_run = 0;
      end
      if (done) begin
        chk("done_count", idx, 192);
        done_rel = rel;
      end
      if (start && !busy) begin
        rel = 0;
        idx = 0;
        gap_run = 0;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
  endtask

  task automatic wait_done(input int bound);
    int n;
    n = 0;
    while (!done && n < bound) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  initial begin
    int bad, ndone, n;
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    chk("reset_outs", {11'd0, out_valid, busy, done, fld}, 0);

    pulse_start();
    wait_done(400);
    chk("last_at_202", last_rel, 202);
    chk("done_at_203", done_rel, 203);
    chk("s0b5", {14'd0, got_f[5][9:4]}, {5'd5, 1'b0});
    chk("s0b16", {14'd0, got_f[16][9:1]}, {5'd16, 1'b1, 3'b101});
    chk("s1b24", {14'd0, got_f[56][9:4]}, {5'd16, 1'b1});
    bad = 0;
    for (int i = 160; i < 192; i++) if (got_f[i][9:1] != {5'd0, 1'b1, 3'b000}) bad++;
    chk("s5_trivial", bad, 0);
    chk("last_flag", got_f[191][0], 1);
    @(posedge clk); #1;
    chk("idle_after", {busy, done, out_valid}, 0);

    pulse_start();
    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      out_ready = 1'($urandom_range(0, 1));
      start = (n == 50);
      n++;
    end
    start = 0;
    if (!done) chk("bp_timeout", 0, 1);
    @(negedge clk); #1;
    out_ready = 1;

    pulse_start();
    n = 0;
    while (!(out_valid && stage == 3 && bfly == 10) && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("abort_reach", {stage, bfly}, {3'd3, 5'd10});
    abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_drop", {out_valid, busy, done}, 0);
    ndone = 0;
    repeat (5) begin
      @(posedge clk); #1;
      ndone += int'(done);
    end
    chk("abort_no_done", ndone, 0);
    pulse_start();
    chk("restart", {out_valid, stage, bfly}, {1'b1, 3'd0, 5'd0});
    wait_done(400);

    pulse_start();
    repeat (20) @(posedge clk);
    #3 rst_n = 0;
    #1 chk("async_reset", {11'd0, out_valid, busy, done, fld}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
    chk("post_reset", {11'd0, out_valid, busy, done, fld}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
